// File: rtl/adder_arbiter.sv
// adder_arbiter: one 32-bit adder shared by NUM_REQ requesters.
//
// Operation:
// - A round-robin arbiter picks one requester per cycle.
// - The sum is registered into a one-entry result buffer, tagged with the
//   requester ID.
// - The result appears one cycle after the handshake. The buffer can drain
//   and refill in the same cycle, so one operation per cycle is sustained.
//
// Optional build macro ADDER_ARB_FLAGS_EN adds two registered outputs:
// - resp_carry: carry-out of the addition.
// - resp_ovf: signed overflow of the addition.
module adder_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_sum,
`ifdef ADDER_ARB_FLAGS_EN
    output logic                    resp_carry,
    output logic                    resp_ovf,
`endif
    output logic [31:0]             op_count
);

    // Result buffer and arbitration state
    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic [31:0]        r_resp_sum;
    logic [31:0]        r_op_count;
    logic [ID_W-1:0]    r_rr_ptr;
`ifdef ADDER_ARB_FLAGS_EN
    logic               r_resp_carry;
    logic               r_resp_ovf;
`endif

    // Unpacked operand views and grant results
    logic [31:0]        w_a [NUM_REQ];
    logic [31:0]        w_b [NUM_REQ];
    logic               w_found;
    logic [ID_W-1:0]    w_grant_id;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [ID_W-1:0]    w_next_ptr;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_can_accept;
    logic               w_fire;
`ifdef ADDER_ARB_FLAGS_EN
    logic [32:0]        w_sum33;
    logic               w_ovf;
`endif
    logic [31:0]        w_sum;

    // Split the packed operand buses into one 32-bit word per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a[32*gi +: 32];
            assign w_b[gi] = req_b[32*gi +: 32];
        end
    endgenerate

    // Rotating priority search.
    // - The search starts at r_rr_ptr and wraps around.
    // - The first valid requester wins.
    // - The winner's operands are muxed onto the single adder.
    always_comb begin
        int ptr_i;
        int idx;
        w_found    = 1'b0;
        w_grant_id = '0;
        w_grant_oh = '0;
        w_next_ptr = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        ptr_i      = int'(r_rr_ptr);
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr_i + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found         = 1'b1;
                w_grant_id      = ID_W'(idx);
                w_grant_oh[idx] = 1'b1;
                w_next_ptr      = ID_W'((idx + 1) % NUM_REQ);
                w_sel_a         = w_a[idx];
                w_sel_b         = w_b[idx];
            end
        end
    end

    // The buffer can take a new result when it is empty or being drained now.
    assign w_can_accept = !r_resp_valid || resp_ready;
    assign w_fire       = w_found && w_can_accept;
    assign req_ready    = (w_can_accept && !rst) ? w_grant_oh : '0;

    // The shared adder.
    // - With flags enabled, a 33-bit add exposes the carry-out.
    // - Without flags, a plain 32-bit add is used and the carry is dropped.
`ifdef ADDER_ARB_FLAGS_EN
    assign w_sum33 = {1'b0, w_sel_a} + {1'b0, w_sel_b};
    assign w_sum   = w_sum33[31:0];
    assign w_ovf   = (w_sel_a[31] == w_sel_b[31]) && (w_sum33[31] != w_sel_a[31]);
`else
    assign w_sum   = w_sel_a + w_sel_b;
`endif

    // Result buffer, round-robin pointer and operation counter.
    // - A handshake loads a new result and takes priority over a drain.
    // - A drain clears only the valid bit; sum and ID keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_sum   <= '0;
            r_op_count   <= '0;
            r_rr_ptr     <= '0;
`ifdef ADDER_ARB_FLAGS_EN
            r_resp_carry <= 1'b0;
            r_resp_ovf   <= 1'b0;
`endif
        end else if (w_fire) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_grant_id;
            r_resp_sum   <= w_sum;
            r_op_count   <= r_op_count + 32'd1;
            r_rr_ptr     <= w_next_ptr;
`ifdef ADDER_ARB_FLAGS_EN
            r_resp_carry <= w_sum33[32];
            r_resp_ovf   <= w_ovf;
`endif
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_resp_sum;
    assign op_count   = r_op_count;
`ifdef ADDER_ARB_FLAGS_EN
    assign resp_carry = r_resp_carry;
    assign resp_ovf   = r_resp_ovf;
`endif

endmodule
